// File: rtl/agu_request_arbiter_pkg.sv
// Shared types, opcode constants and the address-forming helper for the AGU request arbiter.
// Optional feature macro: AGU_MISALIGN_CHECK_EN enables the misalignment flag.
package agu_request_arbiter_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] address;
        logic            err;
        logic            misaligned;
    } agu_result_t;

    // Operand select, 32-bit wrapping add and optional misalignment flag for one request
    function automatic agu_result_t agu_compute(
        input logic [OPC_W-1:0] opcode,
        input logic [F3_W-1:0]  funct3,
        input logic [XLEN-1:0]  rs1,
        input logic [XLEN-1:0]  pc,
        input logic [XLEN-1:0]  imm
    );
        agu_result_t r;
        logic        unused_f3;
        r = '0;
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_JALR:  r.address = rs1 + imm;
            OPC_JAL, OPC_AUIPC, OPC_BRANCH: r.address = pc + imm;
            default:                        r.err     = 1'b1;
        endcase
`ifdef AGU_MISALIGN_CHECK_EN
        unused_f3 = funct3[2];
        if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
            if (funct3[1:0] == 2'b01 && r.address[0])
                r.misaligned = 1'b1;
            if (funct3[1:0] == 2'b10 && r.address[1:0] != 2'b00)
                r.misaligned = 1'b1;
        end
        if ((opcode == OPC_JAL || opcode == OPC_JALR || opcode == OPC_BRANCH) && r.address[1])
            r.misaligned = 1'b1;
`else
        unused_f3 = ^funct3;
`endif
        return r;
    endfunction

endpackage

// File: rtl/agu_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr, wrapping.
module agu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic found;

    // Search ptr..NUM_REQ-1 first, then wrap around to 0..ptr-1
    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req[i] && ID_W'(i) >= ptr) begin
                found = 1'b1;
                idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            grant[i] = found && (idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/agu_request_arbiter.sv
// Shares one 32-bit address adder between NUM_REQ requesters behind a one-entry output register.
// Optional feature macro: AGU_MISALIGN_CHECK_EN (misalignment flag; tied 0 when undefined).
module agu_request_arbiter
    import agu_request_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPC_W-1:0]  req_opcode,
    input  logic [NUM_REQ*F3_W-1:0]   req_funct3,
    input  logic [NUM_REQ*XLEN-1:0]   req_rs1,
    input  logic [NUM_REQ*XLEN-1:0]   req_pc,
    input  logic [NUM_REQ*XLEN-1:0]   req_imm,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [XLEN-1:0]           resp_address,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_err,
    output logic                      resp_misaligned
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    agu_result_t   result_q, result_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               can_load;
    logic               req_hs;
    logic [OPC_W-1:0]   sel_opcode;
    logic [F3_W-1:0]    sel_funct3;
    logic [XLEN-1:0]    sel_rs1, sel_pc, sel_imm;
    agu_result_t        new_result;

    agu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // Route the granted requester's payload to the shared adder
    always_comb begin
        sel_opcode = '0;
        sel_funct3 = '0;
        sel_rs1    = '0;
        sel_pc     = '0;
        sel_imm    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                sel_opcode = req_opcode[OPC_W*i +: OPC_W];
                sel_funct3 = req_funct3[F3_W*i +: F3_W];
                sel_rs1    = req_rs1[XLEN*i +: XLEN];
                sel_pc     = req_pc[XLEN*i +: XLEN];
                sel_imm    = req_imm[XLEN*i +: XLEN];
            end
        end
        new_result = agu_compute(sel_opcode, sel_funct3, sel_rs1, sel_pc, sel_imm);
    end

    // Next-state, pointer advance and request acceptance
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        can_load  = (state_q == ST_EMPTY) || resp_ready;
        req_hs    = can_load && (|req_valid) && !reset;
        req_ready = gnt & {NUM_REQ{can_load && !reset}};
        if (req_hs) begin
            state_d  = ST_FULL;
            result_d = new_result;
            id_d     = gnt_idx;
            ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (state_q == ST_FULL && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State and output register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign resp_valid      = (state_q == ST_FULL);
    assign resp_address    = result_q.address;
    assign resp_id         = id_q;
    assign resp_err        = result_q.err;
    assign resp_misaligned = result_q.misaligned;

endmodule

// File: tb/tb_agu_request_arbiter.sv
// Self-checking bench for agu_request_arbiter: directed cases plus randomized traffic vs a reference model.
module tb_agu_request_arbiter;

    localparam int unsigned N    = 2;
    localparam int unsigned ID_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*7-1:0]    req_opcode;
    logic [N*3-1:0]    req_funct3;
    logic [N*32-1:0]   req_rs1, req_pc, req_imm;
    logic              resp_valid, resp_ready;
    logic [31:0]       resp_address;
    logic [ID_W-1:0]   resp_id;
    logic              resp_err, resp_misaligned;

    logic [6:0]  op  [N];
    logic [2:0]  f3  [N];
    logic [31:0] rs1 [N];
    logic [31:0] pc  [N];
    logic [31:0] imm [N];

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    bit          m_valid;
    logic [31:0] m_addr;
    int          m_id;
    bit          m_err, m_mis;
    int          m_ptr;
    bit          m_check_data;
    logic [N-1:0] pending;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            req_opcode[7*i +: 7]  = op[i];
            req_funct3[3*i +: 3]  = f3[i];
            req_rs1[32*i +: 32]   = rs1[i];
            req_pc[32*i +: 32]    = pc[i];
            req_imm[32*i +: 32]   = imm[i];
        end
    end

    agu_request_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_opcode      (req_opcode),
        .req_funct3      (req_funct3),
        .req_rs1         (req_rs1),
        .req_pc          (req_pc),
        .req_imm         (req_imm),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_address    (resp_address),
        .resp_id         (resp_id),
        .resp_err        (resp_err),
        .resp_misaligned (resp_misaligned)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Address rules written straight from the opcode table
    task automatic ref_addr(input logic [6:0] o, input logic [2:0] fn, input logic [31:0] r1,
                            input logic [31:0] p, input logic [31:0] im,
                            output logic [31:0] a, output bit e, output bit mis);
        longint unsigned s;
        a = 32'h0; e = 1'b0; mis = 1'b0;
        if (o == 7'h03 || o == 7'h23 || o == 7'h67) begin
            s = longint'(r1) + longint'(im);
            a = s[31:0];
        end else if (o == 7'h6F || o == 7'h17 || o == 7'h63) begin
            s = longint'(p) + longint'(im);
            a = s[31:0];
        end else begin
            e = 1'b1;
        end
`ifdef AGU_MISALIGN_CHECK_EN
        if ((o == 7'h03 || o == 7'h23) && fn[1:0] == 2'b01 && (a % 2) != 0) mis = 1'b1;
        if ((o == 7'h03 || o == 7'h23) && fn[1:0] == 2'b10 && (a % 4) != 0) mis = 1'b1;
        if ((o == 7'h6F || o == 7'h67 || o == 7'h63) && ((a / 2) % 2) == 1) mis = 1'b1;
`else
        if (fn == 3'd7 && 1'b0) mis = 1'b1;
`endif
    endtask

    // One clock: check acceptance, advance the model, then check registered outputs
    task automatic cycle();
        int          g;
        bit          can_load;
        logic [N-1:0] exp_ready;
        logic [31:0] a;
        bit          e, mis;
        #1;
        g = -1;
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_ptr + k) % int'(N);
            if (g < 0 && req_valid[j]) g = j;
        end
        can_load  = !m_valid || resp_ready;
        exp_ready = '0;
        if (!reset && can_load && g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        pending = req_valid & ~exp_ready;
        if (reset) begin
            m_valid = 0; m_addr = 0; m_id = 0; m_err = 0; m_mis = 0; m_ptr = 0;
            m_check_data = 1;
        end else if (exp_ready != '0) begin
            ref_addr(op[g], f3[g], rs1[g], pc[g], imm[g], a, e, mis);
            m_valid = 1; m_addr = a; m_id = g; m_err = e; m_mis = mis;
            m_ptr = (g + 1) % int'(N);
            m_check_data = 1;
        end else if (m_valid && resp_ready) begin
            m_valid = 0;
            m_check_data = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("resp_valid", 64'(resp_valid), 64'(m_valid));
        if (m_check_data) begin
            check("resp_address", 64'(resp_address), 64'(m_addr));
            check("resp_id", 64'(resp_id), 64'(m_id));
            check("resp_err", 64'(resp_err), 64'(m_err));
            check("resp_misaligned", 64'(resp_misaligned), 64'(m_mis));
        end
    endtask

    task automatic set_req(input int i, input logic [6:0] o, input logic [2:0] fn,
                           input logic [31:0] r1, input logic [31:0] p, input logic [31:0] im);
        op[i] = o; f3[i] = fn; rs1[i] = r1; pc[i] = p; imm[i] = im;
    endtask

    function automatic logic [6:0] rand_opcode();
        logic [6:0] tbl [8];
        tbl[0] = 7'h03; tbl[1] = 7'h23; tbl[2] = 7'h6F; tbl[3] = 7'h67;
        tbl[4] = 7'h17; tbl[5] = 7'h63; tbl[6] = 7'h33; tbl[7] = 7'($urandom);
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            1:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int exp_ids [4];

    initial begin
        reset = 1'b1; req_valid = '0; resp_ready = 1'b0; pending = '0;
        m_valid = 0; m_ptr = 0; m_check_data = 0;
        for (int i = 0; i < int'(N); i++) set_req(i, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);

        // reset and idle
        cycle();
        cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            resp_ready = 1'($urandom);
            cycle();
            check("idle_ready", 64'(req_ready), 64'h0);
            check("idle_valid", 64'(resp_valid), 64'h0);
        end

        // LOAD with wrap-around immediate
        resp_ready = 1'b1;
        set_req(0, 7'h03, 3'b010, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC);
        req_valid = 2'b01;
        cycle();
        req_valid = '0;
        check("ld_addr", 64'(resp_address), 64'h0000_0FFC);
        check("ld_id", 64'(resp_id), 64'h0);
        check("ld_err", 64'(resp_err), 64'h0);
        cycle();

        // both requesters valid: alternating grants starting after requester 0
        set_req(1, 7'h23, 3'b000, 32'h2000, 32'h0, 32'h10);
        req_valid = 2'b11;
        exp_ids[0] = 1; exp_ids[1] = 0; exp_ids[2] = 1; exp_ids[3] = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("rr_id", 64'(resp_id), 64'(exp_ids[c]));
        end

        // backpressure for 3 cycles, then a same-edge swap
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("bp_ready", 64'(req_ready), 64'h0);
            check("bp_id", 64'(resp_id), 64'h0);
            check("bp_addr", 64'(resp_address), 64'h0000_0FFC);
        end
        resp_ready = 1'b1;
        req_valid  = 2'b10;
        cycle();
        check("swap_id", 64'(resp_id), 64'h1);
        check("swap_addr", 64'(resp_address), 64'h0000_2010);
        req_valid = '0;
        cycle();

        // JAL wrap and unsupported opcode
        set_req(0, 7'h6F, 3'b000, 32'h0, 32'hFFFF_FFF0, 32'h20);
        req_valid = 2'b01;
        cycle();
        check("jal_addr", 64'(resp_address), 64'h0000_0010);
        set_req(0, 7'h33, 3'b000, 32'h1234, 32'h5678, 32'h9);
        cycle();
        check("bad_addr", 64'(resp_address), 64'h0);
        check("bad_err", 64'(resp_err), 64'h1);

        // misaligned word load
        set_req(0, 7'h03, 3'b010, 32'h0000_1000, 32'h0, 32'h2);
        cycle();
        check("mis_addr", 64'(resp_address), 64'h0000_1002);
`ifdef AGU_MISALIGN_CHECK_EN
        check("mis_flag", 64'(resp_misaligned), 64'h1);
`else
        check("mis_flag", 64'(resp_misaligned), 64'h0);
`endif

        // reset while FULL drops the response
        req_valid  = '0;
        resp_ready = 1'b0;
        reset      = 1'b1;
        cycle();
        check("rst_full_valid", 64'(resp_valid), 64'h0);
        reset = 1'b0;

        // randomized traffic honouring payload hold while valid & !ready
        pending = '0;
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 59) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(N); i++) begin
                if (!pending[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_req(i, rand_opcode(), 3'($urandom), rand_word(), rand_word(), rand_word());
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
